// File: rtl/i2c_pkg.sv
// Shared widths, response layout and sequencer state encoding for the I2C command sequencer.
package i2c_pkg;

   localparam int ADDR_W = 7;
   localparam int DATA_W = 8;
   localparam int CMD_W  = ADDR_W + DATA_W;
   localparam int RSP_W  = DATA_W + 2;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ISSUE     = 3'd1,
      WAIT_BUSY = 3'd2,
      WAIT_DONE = 3'd3,
      CAPTURE   = 3'd4
   } seq_state_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/i2c_sync_fifo.sv
// First-word-fall-through synchronous FIFO; a push into a full FIFO succeeds when a pop happens in the same cycle.
module i2c_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W:0]   wr_q, wr_d, rd_q, rd_d;
   logic             do_push_s, do_pop_s;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign empty_o   = (wr_q == rd_q);
   assign full_o    = (wr_q[PTR_W] != rd_q[PTR_W]) && (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
   assign do_pop_s  = pop_i & ~empty_o;
   assign do_push_s = push_i & (~full_o | do_pop_s);
   assign wr_d      = do_push_s ? (wr_q + PTR_ONE) : wr_q;
   assign rd_d      = do_pop_s ? (rd_q + PTR_ONE) : rd_q;
   assign dout_o    = empty_o ? '0 : mem_q[rd_q[PTR_W-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_q[wr_q[PTR_W-1:0]] <= din_i;
      end
   end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Queues host write commands, issues them one at a time to the I2C master and queues the results.
// Optional transaction watchdog in WAIT_DONE is enabled by defining I2C_SEQ_TIMEOUT_EN.
module i2c_cmd_sequencer
   import i2c_pkg::*;
#(
   parameter int CMD_DEPTH        = 4,
   parameter int RSP_DEPTH        = 4,
   parameter int TIMEOUT_CYCLES   = 65535,
   parameter int BUSY_WAIT_CYCLES = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_ack,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] m_slave_addr,
   output logic [DATA_W-1:0] m_data_in,
   output logic              m_start,
   input  logic [DATA_W-1:0] m_data_out,
   input  logic              m_ack,
   input  logic              m_busy,
   output logic              seq_idle
);

   localparam int CNT_W = $clog2(max_int(BUSY_WAIT_CYCLES, TIMEOUT_CYCLES) + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] BUSY_LIM = CNT_W'(BUSY_WAIT_CYCLES - 1);
`ifdef I2C_SEQ_TIMEOUT_EN
   localparam logic [CNT_W-1:0] TOUT_LIM = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

   seq_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc_s;
   logic              err_q, err_d, tout_q, tout_d, start_q, start_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              cmd_full_s, cmd_empty_s, cmd_push_s, cmd_pop_s;
   logic [CMD_W-1:0]  cmd_dout_s;
   logic              rsp_full_s, rsp_empty_s, rsp_push_s, rsp_pop_s;
   logic [RSP_W-1:0]  rsp_din_s, rsp_dout_s;

   assign cmd_push_s = cmd_valid & ~cmd_full_s;
   assign rsp_pop_s  = rsp_ready & ~rsp_empty_s;
   assign cnt_inc_s  = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_W'(1));

   i2c_sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
      .clk(clk), .rst_n(rst_n), .push_i(cmd_push_s), .pop_i(cmd_pop_s),
      .din_i({cmd_addr, cmd_data}), .dout_o(cmd_dout_s), .full_o(cmd_full_s), .empty_o(cmd_empty_s)
   );

   i2c_sync_fifo #(.WIDTH(RSP_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
      .clk(clk), .rst_n(rst_n), .push_i(rsp_push_s), .pop_i(rsp_pop_s),
      .din_i(rsp_din_s), .dout_o(rsp_dout_s), .full_o(rsp_full_s), .empty_o(rsp_empty_s)
   );

   // Issuing only with a free response slot means CAPTURE can never be refused.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      err_d      = err_q;
      tout_d     = tout_q;
      addr_d     = addr_q;
      data_d     = data_q;
      start_d    = 1'b0;
      cmd_pop_s  = 1'b0;
      rsp_push_s = 1'b0;
      rsp_din_s  = tout_q ? {{DATA_W{1'b0}}, 1'b0, 1'b1} : {m_data_out, m_ack, err_q};
      case (state_q)
         IDLE: begin
            if (!cmd_empty_s && !rsp_full_s && !m_busy) begin
               cmd_pop_s = 1'b1;
               addr_d    = cmd_dout_s[CMD_W-1:DATA_W];
               data_d    = cmd_dout_s[DATA_W-1:0];
               start_d   = 1'b1;
               state_d   = ISSUE;
            end else begin
               state_d   = IDLE;
            end
         end
         ISSUE: begin
            cnt_d   = '0;
            err_d   = 1'b0;
            tout_d  = 1'b0;
            state_d = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (m_busy) begin
               cnt_d   = '0;
               state_d = WAIT_DONE;
            end else if (cnt_q >= BUSY_LIM) begin
               err_d   = 1'b1;
               state_d = CAPTURE;
            end else begin
               cnt_d   = cnt_inc_s;
            end
         end
         WAIT_DONE: begin
`ifdef I2C_SEQ_TIMEOUT_EN
            if (!m_busy) begin
               state_d = CAPTURE;
            end else if (cnt_q >= TOUT_LIM) begin
               err_d   = 1'b1;
               tout_d  = 1'b1;
               state_d = CAPTURE;
            end else begin
               cnt_d   = cnt_inc_s;
            end
`else
            if (!m_busy) begin
               state_d = CAPTURE;
            end else begin
               state_d = WAIT_DONE;
            end
`endif
         end
         CAPTURE: begin
            rsp_push_s = 1'b1;
            state_d    = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         tout_q  <= 1'b0;
         start_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         tout_q  <= tout_d;
         start_q <= start_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   assign cmd_ready    = ~cmd_full_s;
   assign rsp_valid    = ~rsp_empty_s;
   assign rsp_data     = rsp_dout_s[RSP_W-1:2];
   assign rsp_ack      = rsp_dout_s[1];
   assign rsp_err      = rsp_dout_s[0];
   assign m_start      = start_q;
   assign m_slave_addr = addr_q;
   assign m_data_in    = data_q;
   assign seq_idle     = (state_q == IDLE) && cmd_empty_s;

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Self-checking bench: a scripted I2C master model plus in-order command/response reference queues.
module tb_i2c_cmd_sequencer;

   localparam int TOUT        = 100;
   localparam int MODE_NORMAL = 0;
   localparam int MODE_NEVER  = 1;
   localparam int MODE_LONG   = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid, cmd_ready;
   logic [6:0] cmd_addr;
   logic [7:0] cmd_data;
   logic       rsp_valid, rsp_ready;
   logic [7:0] rsp_data;
   logic       rsp_ack, rsp_err;
   logic [6:0] m_slave_addr;
   logic [7:0] m_data_in;
   logic       m_start;
   logic [7:0] m_data_out;
   logic       m_ack, m_busy;
   logic       seq_idle;

   always #5 clk = ~clk;

   i2c_cmd_sequencer #(.CMD_DEPTH(4), .RSP_DEPTH(4), .TIMEOUT_CYCLES(TOUT), .BUSY_WAIT_CYCLES(15)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_ack(rsp_ack), .rsp_err(rsp_err),
      .m_slave_addr(m_slave_addr), .m_data_in(m_data_in), .m_start(m_start),
      .m_data_out(m_data_out), .m_ack(m_ack), .m_busy(m_busy), .seq_idle(seq_idle)
   );

   typedef struct {
      int         mode;
      int         dly;
      int         len;
      logic [7:0] d;
      logic       a;
   } plan_t;

   plan_t       plan_q[$];
   logic [14:0] cmd_q[$];
   logic [14:0] iss_q[$];
   logic [9:0]  exp_q[$];
   int n_cmp = 0, n_err = 0;
   int cyc = 0, start_hi = 0, start_cyc = 0, iss_total = 0;

   // Expected response of one transaction, derived from how the master behaves for it.
   function automatic logic [9:0] exp_rsp(input plan_t p);
      if (p.mode == MODE_NEVER) return {p.d, p.a, 1'b1};
`ifdef I2C_SEQ_TIMEOUT_EN
      if (p.mode == MODE_LONG) return 10'h001;
`endif
      return {p.d, p.a, 1'b0};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_cmd(input logic [6:0] a, input logic [7:0] d, input plan_t p);
      int w = 0;
      cmd_valid = 1'b1;
      cmd_addr  = a;
      cmd_data  = d;
      while (!cmd_ready && w < 500) begin
         step();
         w++;
      end
      chk("push_wait", 32'(w < 500), 32'd1);
      step();
      cmd_valid = 1'b0;
      cmd_q.push_back({a, d});
      plan_q.push_back(p);
   endtask

   task automatic drain(input int n, input bit rnd, input string tag);
      int got = 0;
      int w = 0;
      while (got < n && w < 5000) begin
         rsp_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) chk({tag, "_unexpected"}, 32'(exp_q.size()), 32'd1);
            else chk(tag, 32'({rsp_data, rsp_ack, rsp_err}), 32'(exp_q.pop_front()));
            got++;
         end
         step();
         w++;
      end
      rsp_ready = 1'b0;
      chk({tag, "_count"}, 32'(got), 32'(n));
   endtask

   task automatic check_issues(input string tag);
      logic [31:0] e;
      while (iss_q.size() > 0) begin
         e = (cmd_q.size() > 0) ? 32'(cmd_q.pop_front()) : 32'hDEAD_BEEF;
         chk(tag, 32'(iss_q.pop_front()), e);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (m_start === 1'b1) begin
         start_hi  <= start_hi + 1;
         start_cyc <= cyc;
      end
   end

   // Master model: on each start pulse, present the planned result and run the planned busy window.
   initial begin : master
      plan_t p;
      m_busy     = 1'b0;
      m_data_out = 8'h00;
      m_ack      = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (m_start === 1'b1 && rst_n === 1'b1) begin
            iss_q.push_back({m_slave_addr, m_data_in});
            iss_total++;
            if (plan_q.size() > 0) p = plan_q.pop_front();
            else p = '{mode: MODE_NORMAL, dly: 0, len: 1, d: 8'h00, a: 1'b0};
            m_data_out = p.d;
            m_ack      = p.a;
            exp_q.push_back(exp_rsp(p));
            if (p.mode != MODE_NEVER) begin
               repeat (p.dly) begin @(posedge clk); #1; end
               m_busy = 1'b1;
               repeat ((p.mode == MODE_LONG) ? TOUT + 50 : p.len) begin @(posedge clk); #1; end
               m_busy = 1'b0;
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin : main
      int s0, w, lat;
      plan_t p;
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = 7'h00; cmd_data = 8'h00; rsp_ready = 1'b0;
      step(3);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_rsp", 32'({rsp_valid, rsp_data, rsp_ack, rsp_err}), 32'd0);
      chk("rst_master_if", 32'({m_start, m_slave_addr, m_data_in}), 32'd0);
      chk("rst_idle", 32'(seq_idle), 32'd1);
      rst_n = 1'b1;
      step(2);

      // Single transaction
      push_cmd(7'h50, 8'hA5, '{mode: MODE_NORMAL, dly: 1, len: 20, d: 8'h3C, a: 1'b1});
      drain(1, 1'b0, "single_rsp");
      check_issues("single_issue");
      chk("single_starts", 32'(start_hi), 32'd1);

      // Fill both FIFOs with no host pops, then drain with continuous ready
      s0 = start_hi;
      for (int i = 0; i < 8; i++)
         push_cmd(7'(8'h10 + i), 8'(8'hC0 + i), '{mode: MODE_NORMAL, dly: 0, len: 3, d: 8'(8'h80 + i), a: i[0]});
      step(100);
      chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("full_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("full_starts", 32'(start_hi - s0), 32'd4);
      chk("full_not_idle", 32'(seq_idle), 32'd0);
      drain(8, 1'b0, "fill_rsp");
      check_issues("fill_issue");
      chk("fill_all_issued", 32'(cmd_q.size()), 32'd0);

      // Busy never rises: ISSUE + 15 WAIT_BUSY + CAPTURE, then the response is visible
      push_cmd(7'h11, 8'h22, '{mode: MODE_NEVER, dly: 0, len: 0, d: 8'h5A, a: 1'b0});
      w = 0;
      while (!rsp_valid && w < 200) begin step(); w++; end
      lat = cyc - start_cyc;
      chk("nobusy_wait", 32'(w < 200), 32'd1);
      chk("nobusy_latency", 32'(lat), 32'd17);
      chk("nobusy_idle", 32'(seq_idle), 32'd1);
      push_cmd(7'h12, 8'h34, '{mode: MODE_NORMAL, dly: 2, len: 5, d: 8'h99, a: 1'b1});
      drain(2, 1'b0, "nobusy_rsp");
      check_issues("nobusy_issue");

`ifdef I2C_SEQ_TIMEOUT_EN
      // Busy stuck high past the watchdog; nothing new issues until busy drops
      s0 = start_hi;
      push_cmd(7'h21, 8'h43, '{mode: MODE_LONG, dly: 0, len: 0, d: 8'hEE, a: 1'b1});
      w = 0;
      while (!rsp_valid && w < 400) begin step(); w++; end
      lat = cyc - start_cyc;
      chk("tout_latency", 32'(lat >= 95 && lat <= 110), 32'd1);
      push_cmd(7'h22, 8'h44, '{mode: MODE_NORMAL, dly: 0, len: 2, d: 8'h66, a: 1'b0});
      w = 0;
      while (m_busy && w < 400) begin step(); w++; end
      chk("tout_hold_start", 32'(start_hi - s0), 32'd1);
      drain(2, 1'b0, "tout_rsp");
      check_issues("tout_issue");
`endif

      // Asynchronous reset while a transaction is in WAIT_DONE with commands queued
      s0 = start_hi;
      push_cmd(7'h30, 8'h01, '{mode: MODE_NORMAL, dly: 0, len: 40, d: 8'h11, a: 1'b1});
      push_cmd(7'h31, 8'h02, '{mode: MODE_NORMAL, dly: 0, len: 2, d: 8'h12, a: 1'b0});
      push_cmd(7'h32, 8'h03, '{mode: MODE_NORMAL, dly: 0, len: 2, d: 8'h13, a: 1'b1});
      step(3);
      chk("prerst_state", 32'({m_busy, seq_idle, m_slave_addr}), 32'({1'b1, 1'b0, 7'h30}));
      #3;
      rst_n = 1'b0;
      #1;
      chk("midrst_master_if", 32'({m_start, m_slave_addr, m_data_in}), 32'd0);
      chk("midrst_status", 32'({cmd_ready, rsp_valid, seq_idle}), 32'b101);
      step(2);
      rst_n = 1'b1;
      w = 0;
      while (m_busy && w < 200) begin step(); w++; end
      step(10);
      chk("postrst_no_issue", 32'(start_hi - s0), 32'd1);
      chk("postrst_rsp", 32'({rsp_valid, rsp_data, rsp_ack, rsp_err}), 32'd0);
      check_issues("rst_issue");
      cmd_q.delete(); plan_q.delete(); exp_q.delete();

      // Randomized traffic with random host back-pressure
      fork
         begin : rand_push
            for (int i = 0; i < 24; i++) begin
               p.mode = ($urandom_range(0, 5) == 0) ? MODE_NEVER : MODE_NORMAL;
               p.dly  = $urandom_range(0, 4);
               p.len  = $urandom_range(1, 8);
               p.d    = 8'($urandom);
               p.a    = 1'($urandom);
               push_cmd(7'($urandom), 8'($urandom), p);
               step($urandom_range(0, 3));
            end
         end
         drain(24, 1'b1, "rand_rsp");
      join
      check_issues("rand_issue");
      chk("rand_all_issued", 32'(cmd_q.size()), 32'd0);
      chk("start_pulse_width", 32'(start_hi), 32'(iss_total));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
